freq_divider_prog: RTL

//   Programmable integer clock divider, successor to the fixed-behaviour divider.

---
 rtl/freq_divider_prog.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/freq_divider_prog.sv
// Programmable integer clock divider.
// Produces a registered divided waveform (ClkOut) and a period-start pulse
// (Tick). Divide ratio and high time are double-buffered: a load lands in a
// shadow register and only becomes active at a period boundary or while the
// divider is idle, so a running output never sees a truncated period.

module freq_divider_prog #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             ConfigDiv,
  input  logic [WIDTH-1:0] DivIn,
  input  logic [WIDTH-1:0] HighIn,
  output logic             ClkOut,
  output logic             Tick,
  output logic             CfgPending
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO    = '0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // Shadow (requested) and active (in-use) configuration.
  logic [WIDTH-1:0] shadow_div;
  logic [WIDTH-1:0] shadow_high;
  logic [WIDTH-1:0] act_div;
  logic [WIDTH-1:0] act_high;

  // Period counter and its next value.
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;

  // Effective (sanitised) divide ratio / high time derived from active config.
  logic [WIDTH-1:0] div_eff;
  logic [WIDTH-1:0] high_eff;
  logic [WIDTH-1:0] last_cnt;
  logic [WIDTH-1:0] half_up;

  logic wrap;
  logic transfer;
  logic clk_out_next;
  logic tick_next;

  // Sanitise the active config: N=0 behaves as N=1, H=0 means ceil(N/2),
  // and an oversized H is clamped so the output always has a low phase.
  always_comb begin
    div_eff  = (act_div == ZERO) ? ONE : act_div;
    last_cnt = div_eff - ONE;
    half_up  = (div_eff >> 1) + {{(WIDTH-1){1'b0}}, div_eff[0]};
    if (div_eff == ONE) begin
      high_eff = ONE;
    end else if (act_high == ZERO) begin
      high_eff = half_up;
    end else if (act_high > last_cnt) begin
      high_eff = last_cnt;
    end else begin
      high_eff = act_high;
    end
  end

  // Wrap marks the last cycle of a period; transfers happen there or whenever idle.
  always_comb begin
    wrap     = Enable && (cnt == last_cnt);
    transfer = !Enable || wrap;
  end

  // State register: IDLE while disabled, RUN while enabled.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: Enable alone decides; stopping is immediate.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Enable)  state_next = RUN;
      RUN:     if (!Enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: next counter value and next registered ClkOut/Tick.
  always_comb begin
    cnt_next     = ZERO;
    clk_out_next = 1'b0;
    tick_next    = 1'b0;
    case (state)
      IDLE: begin
        if (Enable) begin
          cnt_next     = ZERO;
          clk_out_next = 1'b1;
          tick_next    = 1'b1;
        end
      end
      RUN: begin
        if (Enable) begin
          cnt_next     = wrap ? ZERO : (cnt + ONE);
          tick_next    = (cnt_next == ZERO);
          clk_out_next = (cnt_next < high_eff);
        end
      end
      default: begin
        cnt_next     = ZERO;
        clk_out_next = 1'b0;
        tick_next    = 1'b0;
      end
    endcase
  end

  // Register the counter and the visible outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt    <= ZERO;
      ClkOut <= 1'b0;
      Tick   <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      ClkOut <= clk_out_next;
      Tick   <= tick_next;
    end
  end

  // Capture a requested config into the shadow registers on a load strobe.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      shadow_div  <= DEF_DIV;
      shadow_high <= ZERO;
    end else if (ConfigDiv) begin
      shadow_div  <= DivIn;
      shadow_high <= HighIn;
    end
  end

  // Move shadow to active at a safe point; the old shadow is what transfers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      act_div  <= DEF_DIV;
      act_high <= ZERO;
    end else if (transfer) begin
      act_div  <= shadow_div;
      act_high <= shadow_high;
    end
  end

  // Pending flag: a new load wins over a simultaneous transfer.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      CfgPending <= 1'b0;
    end else if (ConfigDiv) begin
      CfgPending <= 1'b1;
    end else if (transfer) begin
      CfgPending <= 1'b0;
    end
  end

endmodule
